// File: rtl/frame_egress_writer.sv
// frame_egress_writer: receives the switch-core frame stream, decodes the 2-byte
// routing header, replicates the body into the per-port data FIFOs and pushes one
// descriptor per stored frame into each targeted pointer FIFO.
// Optional feature macro: FRAME_DROP_CNT_EN (adds the saturating drop_cnt output).

module frame_egress_writer (
  input  logic        clk,
  input  logic        rst,
  input  logic        sof,
  input  logic        dv,
  input  logic [7:0]  data,
  input  logic [3:0]  dfifo_afull,
  input  logic [3:0]  pfifo_full,
  output logic [3:0]  dfifo_wr,
  output logic [7:0]  dfifo_din,
  output logic [3:0]  pfifo_wr,
  output logic [15:0] pfifo_din,
  output logic        bp0,
  output logic        bp1,
  output logic        bp2,
  output logic        bp3
`ifdef FRAME_DROP_CNT_EN
  ,
  output logic [15:0] drop_cnt
`endif
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_HDR1    = 2'd1;
  localparam logic [1:0] S_BODY    = 2'd2;
  localparam logic [1:0] S_DISCARD = 2'd3;

  localparam logic [11:0] MaxCount = 12'hFFF;

  logic [1:0]  r_state;
  logic [3:0]  r_portmap;
  logic [3:0]  r_wmask;
  logic [11:0] r_len;
  logic [11:0] r_count;
  logic        r_ovf;      // bytes arrived after count saturated
  logic [3:0]  r_dfifo_wr;
  logic [7:0]  r_dfifo_din;
  logic [3:0]  r_pfifo_wr;
  logic [15:0] r_pfifo_din;
  logic [3:0]  r_bp;

  logic [3:0]  w_busy;
  logic        w_admit;

  assign w_busy  = dfifo_afull | pfifo_full;
  assign w_admit = (r_portmap != 4'd0) && ((r_portmap & w_busy) == 4'd0);

  // Header decode, admission, body replication and descriptor generation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_portmap   <= 4'd0;
      r_wmask     <= 4'd0;
      r_len       <= 12'd0;
      r_count     <= 12'd0;
      r_ovf       <= 1'b0;
      r_dfifo_wr  <= 4'd0;
      r_dfifo_din <= 8'd0;
      r_pfifo_wr  <= 4'd0;
      r_pfifo_din <= 16'd0;
    end else begin
      r_dfifo_wr <= 4'd0;
      r_pfifo_wr <= 4'd0;
      case (r_state)
        S_IDLE: begin
          if (sof && dv) begin
            r_portmap   <= data[3:0];
            r_len[11:8] <= data[7:4];
            r_state     <= S_HDR1;
          end
        end
        S_HDR1: begin
          if (dv) begin
            r_len[7:0] <= data;
            r_count    <= 12'd0;
            r_ovf      <= 1'b0;
            if (w_admit) begin
              r_wmask <= r_portmap;
              r_state <= S_BODY;
            end else begin
              r_state <= S_DISCARD;
            end
          end else begin
            // Runt frame: header truncated, nothing written.
            r_state <= S_IDLE;
          end
        end
        S_BODY: begin
          if (dv && sof) begin
            // Missing gap: close the frame as mismatched and start the next header.
            r_pfifo_wr  <= r_wmask;
            r_pfifo_din <= {1'b1, 3'b000, r_count};
            r_portmap   <= data[3:0];
            r_len[11:8] <= data[7:4];
            r_state     <= S_HDR1;
          end else if (dv) begin
            if (r_count != MaxCount) begin
              r_dfifo_wr  <= r_wmask;
              r_dfifo_din <= data;
              r_count     <= r_count + 12'd1;
            end else begin
              r_ovf <= 1'b1;
            end
          end else begin
            r_pfifo_wr  <= r_wmask;
            r_pfifo_din <= {((r_count != r_len) | r_ovf), 3'b000, r_count};
            r_state     <= S_IDLE;
          end
        end
        S_DISCARD: begin
          if (dv && sof) begin
            r_portmap   <= data[3:0];
            r_len[11:8] <= data[7:4];
            r_state     <= S_HDR1;
          end else if (!dv) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Backpressure: registered copy of the per-port FIFO congestion flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bp <= 4'd0;
    end else begin
      r_bp <= w_busy;
    end
  end

  assign dfifo_wr  = r_dfifo_wr;
  assign dfifo_din = r_dfifo_din;
  assign pfifo_wr  = r_pfifo_wr;
  assign pfifo_din = r_pfifo_din;
  assign bp0       = r_bp[0];
  assign bp1       = r_bp[1];
  assign bp2       = r_bp[2];
  assign bp3       = r_bp[3];

`ifdef FRAME_DROP_CNT_EN
  logic [15:0] r_drop_cnt;
  logic        w_drop;

  // A frame is dropped when a runt ends in HDR1 or a discarded frame ends.
  assign w_drop = ((r_state == S_HDR1) && !dv) ||
                  ((r_state == S_DISCARD) && (!dv || sof));

  // Saturating dropped-frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= 16'd0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_frame_egress_writer.sv
// tb_frame_egress_writer: scoreboard bench for frame_egress_writer. Stimulus tasks push
// expected data writes and descriptors into queues; a negedge monitor pops and compares.
// Honours FRAME_DROP_CNT_EN to check drop_cnt when the feature is built in.

module tb_frame_egress_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        sof;
  logic        dv;
  logic [7:0]  data;
  logic [3:0]  dfifo_afull;
  logic [3:0]  pfifo_full;
  logic [3:0]  dfifo_wr;
  logic [7:0]  dfifo_din;
  logic [3:0]  pfifo_wr;
  logic [15:0] pfifo_din;
  logic        bp0, bp1, bp2, bp3;
`ifdef FRAME_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  always #5 clk = ~clk;

  frame_egress_writer dut (
    .clk         (clk),
    .rst         (rst),
    .sof         (sof),
    .dv          (dv),
    .data        (data),
    .dfifo_afull (dfifo_afull),
    .pfifo_full  (pfifo_full),
    .dfifo_wr    (dfifo_wr),
    .dfifo_din   (dfifo_din),
    .pfifo_wr    (pfifo_wr),
    .pfifo_din   (pfifo_din),
    .bp0         (bp0),
    .bp1         (bp1),
    .bp2         (bp2),
    .bp3         (bp3)
`ifdef FRAME_DROP_CNT_EN
    ,
    .drop_cnt    (drop_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;
  int exp_drop = 0;

  logic [11:0] data_q[$];   // {mask, byte}
  logic [19:0] desc_q[$];   // {mask, descriptor}

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  // Monitor: every strobe must match the head of its expectation queue.
  logic [11:0] mon_d;
  logic [19:0] mon_p;
  always @(negedge clk) begin
    if (dfifo_wr != 4'd0) begin
      checks++;
      if (data_q.size() == 0) begin
        failures++;
        $display("FAIL data_unexpected: got wr=%b din=%h required no write", dfifo_wr, dfifo_din);
      end else begin
        mon_d = data_q.pop_front();
        if ({dfifo_wr, dfifo_din} !== mon_d) begin
          failures++;
          $display("FAIL data_write: got %b/%h required %b/%h",
                   dfifo_wr, dfifo_din, mon_d[11:8], mon_d[7:0]);
        end
      end
    end
    if (pfifo_wr != 4'd0) begin
      checks++;
      if (desc_q.size() == 0) begin
        failures++;
        $display("FAIL desc_unexpected: got wr=%b din=%h required no write", pfifo_wr, pfifo_din);
      end else begin
        mon_p = desc_q.pop_front();
        if ({pfifo_wr, pfifo_din} !== mon_p) begin
          failures++;
          $display("FAIL desc_write: got %b/%h required %b/%h",
                   pfifo_wr, pfifo_din, mon_p[19:16], mon_p[15:0]);
        end
      end
      checks++;
      if (dfifo_wr != 4'd0) begin
        failures++;
        $display("FAIL desc_concurrent: got dfifo_wr=%b required 0000", dfifo_wr);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic count_drop();
    if (exp_drop < 65535) exp_drop++;
  endtask

  task automatic chk_drop();
`ifdef FRAME_DROP_CNT_EN
    chk("drop_cnt", {16'd0, drop_cnt}, exp_drop);
`endif
  endtask

  // Change the congestion flags and check bp lags them by exactly one cycle.
  task automatic set_flags(input logic [3:0] afull, input logic [3:0] pfull);
    logic [3:0] prev;
    prev        = dfifo_afull | pfifo_full;
    dfifo_afull = afull;
    pfifo_full  = pfull;
    @(negedge clk);
    chk("bp_before", {28'd0, bp3, bp2, bp1, bp0}, {28'd0, prev});
    cyc();
    chk("bp_after", {28'd0, bp3, bp2, bp1, bp0}, {28'd0, (afull | pfull)});
  endtask

  // Send one frame; chain=1 leaves dv high so the next sof follows with no gap.
  task automatic send_frame(input logic [3:0] pm, input logic [11:0] ln, input int n,
                            input bit chain);
    logic [3:0] busy;
    bit         admit;
    int         stored;
    logic       mis;
    logic [7:0] b;
    busy   = dfifo_afull | pfifo_full;
    admit  = (pm != 4'd0) && ((pm & busy) == 4'd0);
    stored = (n > 4095) ? 4095 : n;
    mis    = chain || (n != int'(ln));
    if (admit) desc_q.push_back({pm, mis, 3'b000, stored[11:0]});
    else       count_drop();
    sof  = 1'b1;
    dv   = 1'b1;
    data = {ln[11:8], pm};
    cyc();
    sof  = 1'b0;
    data = ln[7:0];
    cyc();
    for (int i = 0; i < n; i++) begin
      b    = 8'($urandom);
      data = b;
      if (admit && i < 4095) data_q.push_back({pm, b});
      cyc();
    end
    if (!chain) begin
      dv   = 1'b0;
      data = 8'($urandom);
      cyc();
    end
  endtask

  task automatic send_runt(input logic [3:0] pm);
    count_drop();
    sof  = 1'b1;
    dv   = 1'b1;
    data = {4'h0, pm};
    cyc();
    sof  = 1'b0;
    dv   = 1'b0;
    cyc();
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    sof  = 1'b0;
    dv   = 1'b0;
    data = 8'd0;
    cyc();
    cyc();
    rst      = 1'b0;
    exp_drop = 0;
    cyc();
  endtask

  initial begin
    logic [3:0]  pm;
    logic [11:0] ln;
    int          n;
    logic [7:0]  b;
    dfifo_afull = 4'd0;
    pfifo_full  = 4'd0;
    do_reset();

    // Reset state.
    chk("rst_dfifo_wr", {28'd0, dfifo_wr}, 32'd0);
    chk("rst_pfifo_wr", {28'd0, pfifo_wr}, 32'd0);
    chk("rst_dfifo_din", {24'd0, dfifo_din}, 32'd0);
    chk("rst_pfifo_din", {16'd0, pfifo_din}, 32'd0);
    chk("rst_bp", {28'd0, bp3, bp2, bp1, bp0}, 32'd0);
    chk_drop();

    // Unicast to port 2, 60 bytes -> descriptor 003C.
    send_frame(4'h4, 12'h03C, 60, 1'b0);
    // Broadcast from port 0, 64 bytes -> descriptor 0040 on ports 1-3.
    send_frame(4'hE, 12'h040, 64, 1'b0);
    chk_drop();

    // Congestion on port 1 with portmap 0011 -> drop.
    set_flags(4'b0010, 4'b0000);
    send_frame(4'h3, 12'h028, 40, 1'b0);
    chk_drop();
    set_flags(4'b0000, 4'b0000);

    // Length mismatch: 64 declared, 62 delivered -> 803E.
    send_frame(4'h1, 12'h040, 62, 1'b0);
    // Missing gap after byte 50 of a 60-byte frame -> 8032, next frame intact.
    send_frame(4'h2, 12'h03C, 50, 1'b1);
    send_frame(4'h2, 12'h01E, 30, 1'b0);
    // Runt frame.
    send_runt(4'h5);
    chk_drop();

    // Reset at byte 20 of an admitted frame.
    sof  = 1'b1;
    dv   = 1'b1;
    data = 8'h08;
    cyc();
    sof  = 1'b0;
    data = 8'h30;
    cyc();
    for (int i = 0; i < 20; i++) begin
      b    = 8'($urandom);
      data = b;
      data_q.push_back({4'h8, b});
      cyc();
    end
    rst = 1'b1;
    dv  = 1'b0;
    cyc();
    @(negedge clk);
    chk("rst_mid_dfifo_wr", {28'd0, dfifo_wr}, 32'd0);
    chk("rst_mid_pfifo_wr", {28'd0, pfifo_wr}, 32'd0);
    rst      = 1'b0;
    exp_drop = 0;
    cyc();
    chk_drop();
    send_frame(4'h8, 12'h019, 25, 1'b0);

    // Oversized frame saturates the count at 4095 with mismatch set.
    send_frame(4'h1, 12'hFFF, 4097, 1'b0);

    // Randomized frames.
    for (int f = 0; f < 40; f++) begin
      case ($urandom_range(0, 3))
        0:       set_flags(4'($urandom), 4'd0);
        1:       set_flags(4'd0, 4'($urandom));
        default: set_flags(4'd0, 4'd0);
      endcase
      pm = 4'($urandom);
      ln = 12'($urandom_range(0, 80));
      n  = ($urandom_range(0, 1) == 0) ? int'(ln) : int'($urandom_range(0, 90));
      if ($urandom_range(0, 9) == 0) send_runt(pm);
      else                           send_frame(pm, ln, n, 1'b0);
      chk_drop();
      if ($urandom_range(0, 4) == 0) begin
        // Stray dv in IDLE must be ignored.
        dv   = 1'b1;
        data = 8'($urandom);
        cyc();
        dv   = 1'b0;
      end
      repeat ($urandom_range(0, 2)) cyc();
    end

    set_flags(4'd0, 4'd0);
    repeat (4) cyc();
    chk("data_q_empty", data_q.size(), 32'd0);
    chk("desc_q_empty", desc_q.size(), 32'd0);
    chk_drop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
